upsamp_fir_qam: RTL and testbench
=================================

Name: upsamp_fir_qam

Overview:
Baseband transmit block. Maps 4-bit symbols to I/Q levels (2 bits per axis, 4-level Gray code). Zero-stuffs the symbols by a programmable upsampling rate and shapes each rail with a fixed 8-tap FIR. Sits between the symbol source and the DAC interface, with a read-only register port for the SPI slave.

Parameters:
NTAPS, 8, FIR length (fixed; coefficients live in the package)
OUT_W, 10, signed output width per rail
SPI_DW, 12, SPI read data width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
data_in  in  4  symbol; [3:2]=I bits, [1:0]=Q bits
valid_data  in  1  data_in valid this cycle (single-cycle strobe, no backpressure)
upsampling_rate  in  9  samples per symbol R; 0 treated as 1
I_out  out  10  signed filtered I sample, registered
Q_out  out  10  signed filtered Q sample, registered
spi_read  in  1  register read strobe
spi_address  in  8  register address
spi_data_out  out  12  registered read data

Behaviour:
- Reset (rst=1 at edge): I_out, Q_out, spi_data_out=0. Delay lines, pending flag, phase counter, overflow flag and symbol counter all 0. Reset mid-stream discards pending and in-flight samples.
- Mapping (Gray), per axis: 00->-3, 01->-1, 11->+1, 10->+3. Levels are 3-bit signed.
- Holding register: at an edge with valid_data=1, store mapped I/Q and set pending=1.
- Phase counter: Reff = max(upsampling_rate,1), sampled every cycle. If phase >= Reff-1, phase wraps to 0; otherwise it increments. Using >= means lowering the rate mid-run cannot strand the counter.
- Upsampler register, each edge: if phase==0 and pending, load the held symbol, clear pending and increment symcount (12-bit, wraps). Otherwise load 0.
- Same-edge case: if phase==0 and valid_data both hold, the old held symbol is emitted and the new one is loaded; pending stays 1.
- Overflow: valid_data while pending=1 and the symbol is not being consumed at that edge sets sticky overflow. The new symbol overwrites the held one. Overflow clears only on reset.
- FIR per rail: shift register x[0..7], where x[0] is the upsampler output. out <= sat10(sum c[j]*x[j]) with full-precision accumulation, saturating to [-512,+511].
- Coefficients c0..c7 = -4, 0, 36, 64, 64, 36, 0, -4.
- Latency: valid_data at edge t, with phase==0 at edge t+1 and nothing pending, gives I_out=c0*sym after edge t+2, then c1*sym after t+3, and so on.
- SPI: at an edge with spi_read=1, spi_data_out <= reg[spi_address]; otherwise it holds its value. Address map:
  0x00 ID = 12'hA64
  0x01 {3'b0, Reff}
  0x02 {overflow, pending, 1'b0, phase[8:0]}
  0x03 symcount
  0x10-0x17 c0-c7, sign-extended
  0x20 I_out, sign-extended
  0x21 Q_out, sign-extended
  all other addresses read 0.

Decomposition:
- Package upsamp_pkg holds:
  - NTAPS, OUT_W, SPI_DW
  - coefficient array
  - Gray-map function
  - SPI address constants
  - saturation function
- Sub-module fir8_sat: 8-tap shift register, MAC and saturation, one instance per rail.
- Top level holds mapper, holding register, phase counter, upsampler and SPI mux.

Test Plan:
1. Reset: hold rst 3 cycles with valid_data=1 -> I_out=Q_out=spi_data_out=0 and phase=0 throughout. Release -> outputs stay 0 until a symbol is accepted.
2. R=4, single valid_data with data_in=1010 (I=Q=+3) -> I_out and Q_out sequence -12,0,108,192,192,108,0,-12, then 0. First nonzero value appears 2 edges after the accepting edge.
3. R=4, data_in=0101 (I=Q=-1) -> sequence 4,0,-36,-64,-64,-36,0,4. Then data_in=1100 (I=+1, Q=-3) -> I and Q follow distinct scaled responses.
4. upsampling_rate=0, valid_data held with 1010 every cycle -> steady state saturates to I_out=+511. With 0000 -> -512. Overflow flag stays 0 (every symbol consumed).
5. R=8, two valid_data pulses 2 cycles apart before phase 0 -> only the second symbol is emitted. Read 0x02 -> bit11=1.
6. SPI reads:
   - 0x00 -> 0xA64
   - 0x12 -> 0x024
   - 0x10 -> 0xFFC
   - 0x01 with rate=0 -> 0x001
   - 0x7F -> 0x000
   - data holds when spi_read=0

Source files
------------

// File: rtl/upsamp_fir_qam_pkg.sv
// Shared constants, pulse-shaping coefficients and arithmetic helpers
// for the QAM upsampling transmitter.
package upsamp_pkg;

    localparam int NTAPS  = 8;
    localparam int OUT_W  = 10;
    localparam int SPI_DW = 12;
    localparam int LVL_W  = 3;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 16;
    localparam int RATE_W = 9;

    localparam logic signed [COEF_W-1:0] COEFFS [NTAPS] = '{
        -8'sd4, 8'sd0, 8'sd36, 8'sd64, 8'sd64, 8'sd36, 8'sd0, -8'sd4
    };

    localparam logic [7:0]        ADDR_ID     = 8'h00;
    localparam logic [7:0]        ADDR_RATE   = 8'h01;
    localparam logic [7:0]        ADDR_STATUS = 8'h02;
    localparam logic [7:0]        ADDR_SYMCNT = 8'h03;
    localparam logic [7:0]        ADDR_I      = 8'h20;
    localparam logic [7:0]        ADDR_Q      = 8'h21;
    localparam logic [4:0]        COEF_PAGE   = 5'h02;
    localparam logic [SPI_DW-1:0] ID_VALUE    = 12'hA64;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 16'sh01FF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 16'shFE00;

    // 4-level Gray mapping of one axis: 00,01,11,10 -> -3,-1,+1,+3
    function automatic logic signed [LVL_W-1:0] gray_map(input logic [1:0] bits);
        logic signed [LVL_W-1:0] lvl;
        case (bits)
            2'b00:   lvl = 3'b101;
            2'b01:   lvl = 3'b111;
            2'b11:   lvl = 3'b001;
            2'b10:   lvl = 3'b011;
            default: lvl = 3'b000;
        endcase
        return lvl;
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = 10'b01_1111_1111;
        end else if (v < SAT_MIN) begin
            r = 10'b10_0000_0000;
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/upsamp_fir_qam_fir8_sat.sv
// One rail of the pulse-shaping filter: tap delay line, full-precision MAC
// and saturation into a registered output.
module fir8_sat
    import upsamp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [LVL_W-1:0] x0,
    output logic signed [OUT_W-1:0] y
);

    logic signed [LVL_W-1:0] taps_r [1:NTAPS-1];
    logic signed [LVL_W-1:0] tap_s  [NTAPS];
    logic signed [ACC_W-1:0] acc_s;

    // x[0] is the upsampler register itself; the rest live here
    always_comb begin
        tap_s[0] = x0;
        for (int k = 1; k < NTAPS; k++) begin
            tap_s[k] = taps_r[k];
        end
    end

    // Multiply-accumulate over all taps
    always_comb begin
        acc_s = {ACC_W{1'b0}};
        for (int k = 0; k < NTAPS; k++) begin
            acc_s = acc_s + ACC_W'(tap_s[k]) * ACC_W'(COEFFS[k]);
        end
    end

    // Delay line shift and saturated output register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < NTAPS; k++) begin
                taps_r[k] <= {LVL_W{1'b0}};
            end
            y <= {OUT_W{1'b0}};
        end else begin
            taps_r[1] <= x0;
            for (int k = 2; k < NTAPS; k++) begin
                taps_r[k] <= taps_r[k-1];
            end
            y <= sat_out(acc_s);
        end
    end

endmodule

// File: rtl/upsamp_fir_qam.sv
// QAM transmit front end: Gray mapping, symbol holding, zero-stuffing
// upsampler, per-rail FIR and a read-only SPI register window.
module upsamp_fir_qam
    import upsamp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              data_in,
    input  logic                    valid_data,
    input  logic [RATE_W-1:0]       upsampling_rate,
    output logic signed [OUT_W-1:0] I_out,
    output logic signed [OUT_W-1:0] Q_out,
    input  logic                    spi_read,
    input  logic [7:0]              spi_address,
    output logic [SPI_DW-1:0]       spi_data_out
);

    logic [RATE_W-1:0]       reff_s;
    logic [RATE_W-1:0]       phase_r;
    logic signed [LVL_W-1:0] held_i_r, held_q_r;
    logic signed [LVL_W-1:0] up_i_r, up_q_r;
    logic                    pending_r;
    logic                    overflow_r;
    logic [11:0]             symcount_r;
    logic                    consume_s;
    logic signed [COEF_W-1:0] coef_sel_s;
    logic [SPI_DW-1:0]       rd_data_s;

    // A rate of zero behaves as one sample per symbol
    always_comb begin
        if (upsampling_rate == 9'd0) begin
            reff_s = 9'd1;
        end else begin
            reff_s = upsampling_rate;
        end
    end

    assign consume_s = (phase_r == 9'd0) && pending_r;

    // Phase counter; >= keeps it from running away when the rate drops
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= 9'd0;
        end else if (phase_r >= reff_s - 9'd1) begin
            phase_r <= 9'd0;
        end else begin
            phase_r <= phase_r + 9'd1;
        end
    end

    // Holding register, overflow tracking and zero-stuffing upsampler
    always_ff @(posedge clk) begin
        if (rst) begin
            held_i_r   <= 3'sd0;
            held_q_r   <= 3'sd0;
            pending_r  <= 1'b0;
            overflow_r <= 1'b0;
            up_i_r     <= 3'sd0;
            up_q_r     <= 3'sd0;
            symcount_r <= 12'd0;
        end else begin
            if (valid_data) begin
                held_i_r  <= gray_map(data_in[3:2]);
                held_q_r  <= gray_map(data_in[1:0]);
                pending_r <= 1'b1;
            end else if (consume_s) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
            if (valid_data && pending_r && !consume_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (consume_s) begin
                up_i_r     <= held_i_r;
                up_q_r     <= held_q_r;
                symcount_r <= symcount_r + 12'd1;
            end else begin
                up_i_r     <= 3'sd0;
                up_q_r     <= 3'sd0;
                symcount_r <= symcount_r;
            end
        end
    end

    fir8_sat u_fir_i (
        .clk (clk),
        .rst (rst),
        .x0  (up_i_r),
        .y   (I_out)
    );

    fir8_sat u_fir_q (
        .clk (clk),
        .rst (rst),
        .x0  (up_q_r),
        .y   (Q_out)
    );

    assign coef_sel_s = COEFFS[spi_address[2:0]];

    // Register map decode
    always_comb begin
        rd_data_s = {SPI_DW{1'b0}};
        case (spi_address)
            ADDR_ID:     rd_data_s = ID_VALUE;
            ADDR_RATE:   rd_data_s = {3'b000, reff_s};
            ADDR_STATUS: rd_data_s = {overflow_r, pending_r, 1'b0, phase_r};
            ADDR_SYMCNT: rd_data_s = symcount_r;
            ADDR_I:      rd_data_s = {{(SPI_DW-OUT_W){I_out[OUT_W-1]}}, I_out};
            ADDR_Q:      rd_data_s = {{(SPI_DW-OUT_W){Q_out[OUT_W-1]}}, Q_out};
            default: begin
                if (spi_address[7:3] == COEF_PAGE) begin
                    rd_data_s = {{(SPI_DW-COEF_W){coef_sel_s[COEF_W-1]}}, coef_sel_s};
                end else begin
                    rd_data_s = {SPI_DW{1'b0}};
                end
            end
        endcase
    end

    // Read data is captured on a strobe and held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_data_out <= {SPI_DW{1'b0}};
        end else if (spi_read) begin
            spi_data_out <= rd_data_s;
        end else begin
            spi_data_out <= spi_data_out;
        end
    end

endmodule

// File: tb/tb_upsamp_fir_qam.sv
// Directed self-checking bench for upsamp_fir_qam.
module tb_upsamp_fir_qam;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        data_in = 4'b0000;
    logic              valid_data = 1'b0;
    logic [8:0]        upsampling_rate = 9'd1;
    logic signed [9:0] I_out;
    logic signed [9:0] Q_out;
    logic              spi_read = 1'b0;
    logic [7:0]        spi_address = 8'h00;
    logic [11:0]       spi_data_out;

    int n_tests = 0;
    int n_fail  = 0;
    int coef [8] = '{-4, 0, 36, 64, 64, 36, 0, -4};

    upsamp_fir_qam dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .valid_data      (valid_data),
        .upsampling_rate (upsampling_rate),
        .I_out           (I_out),
        .Q_out           (Q_out),
        .spi_read        (spi_read),
        .spi_address     (spi_address),
        .spi_data_out    (spi_data_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        valid_data = 1'b0;
        spi_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        upsampling_rate = 9'd1;
        valid_data = 1'b1;
        data_in = 4'b1010;
        repeat (4) tick();
        rst = 1'b1;
        spi_read = 1'b1;
        spi_address = 8'h00;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (I_out !== 10'sd0 || Q_out !== 10'sd0 || spi_data_out !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: I=%0d Q=%0d spi=%h, expected all 0", c, I_out, Q_out, spi_data_out);
            end
        end
        rst = 1'b0;
        valid_data = 1'b0;
        spi_address = 8'h02;
        tick();
        n_tests++;
        if (spi_data_out !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected 000", spi_data_out);
        end
        spi_read = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (I_out !== 10'sd0 || Q_out !== 10'sd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: I=%0d Q=%0d expected 0", c, I_out, Q_out);
            end
        end
    endtask

    task automatic test_impulse();
        logic [3:0] dats [3] = '{4'b1010, 4'b0101, 4'b1100};
        int lis [3] = '{3, -1, 1};
        int lqs [3] = '{3, -1, -3};
        upsampling_rate = 9'd4;
        for (int t = 0; t < 3; t++) begin
            apply_reset();
            repeat (3) tick();
            valid_data = 1'b1;
            data_in = dats[t];
            tick();
            valid_data = 1'b0;
            tick();
            n_tests++;
            if (I_out !== 10'sd0 || Q_out !== 10'sd0) begin
                n_fail++;
                $display("FAIL impulse%0d_early: I=%0d Q=%0d expected 0", t, I_out, Q_out);
            end
            for (int k = 0; k < 8; k++) begin
                tick();
                n_tests++;
                if (int'(I_out) !== coef[k] * lis[t] || int'(Q_out) !== coef[k] * lqs[t]) begin
                    n_fail++;
                    $display("FAIL impulse%0d_tap%0d: I=%0d Q=%0d expected I=%0d Q=%0d",
                             t, k, I_out, Q_out, coef[k] * lis[t], coef[k] * lqs[t]);
                end
            end
            tick();
            n_tests++;
            if (I_out !== 10'sd0 || Q_out !== 10'sd0) begin
                n_fail++;
                $display("FAIL impulse%0d_tail: I=%0d Q=%0d expected 0", t, I_out, Q_out);
            end
        end
    endtask

    task automatic test_saturation();
        upsampling_rate = 9'd0;
        apply_reset();
        valid_data = 1'b1;
        data_in = 4'b1010;
        repeat (12) tick();
        n_tests++;
        if (int'(I_out) !== 511 || int'(Q_out) !== 511) begin
            n_fail++;
            $display("FAIL sat_pos: I=%0d Q=%0d expected 511", I_out, Q_out);
        end
        data_in = 4'b0000;
        repeat (12) tick();
        n_tests++;
        if (int'(I_out) !== -512 || int'(Q_out) !== -512) begin
            n_fail++;
            $display("FAIL sat_neg: I=%0d Q=%0d expected -512", I_out, Q_out);
        end
        valid_data = 1'b0;
        spi_read = 1'b1;
        spi_address = 8'h02;
        tick();
        n_tests++;
        if (spi_data_out !== 12'h400) begin
            n_fail++;
            $display("FAIL sat_status: got %h expected 400", spi_data_out);
        end
        spi_address = 8'h01;
        tick();
        n_tests++;
        if (spi_data_out !== 12'h001) begin
            n_fail++;
            $display("FAIL rate_zero_read: got %h expected 001", spi_data_out);
        end
        spi_read = 1'b0;
    endtask

    task automatic test_overflow();
        upsampling_rate = 9'd8;
        apply_reset();
        tick();
        valid_data = 1'b1;
        data_in = 4'b1010;
        tick();
        valid_data = 1'b0;
        tick();
        valid_data = 1'b1;
        data_in = 4'b0101;
        tick();
        valid_data = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (I_out !== 10'sd0 || Q_out !== 10'sd0) begin
            n_fail++;
            $display("FAIL ovf_early: I=%0d Q=%0d expected 0", I_out, Q_out);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if (int'(I_out) !== -coef[k] || int'(Q_out) !== -coef[k]) begin
                n_fail++;
                $display("FAIL ovf_tap%0d: I=%0d Q=%0d expected %0d", k, I_out, Q_out, -coef[k]);
            end
        end
        spi_read = 1'b1;
        spi_address = 8'h02;
        tick();
        n_tests++;
        if (spi_data_out[11:10] !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_flag: status=%h expected bit11=1 bit10=0", spi_data_out);
        end
        spi_address = 8'h03;
        tick();
        n_tests++;
        if (spi_data_out !== 12'h001) begin
            n_fail++;
            $display("FAIL ovf_symcount: got %h expected 001", spi_data_out);
        end
        spi_read = 1'b0;
    endtask

    task automatic test_spi();
        logic [7:0]  addrs [5] = '{8'h00, 8'h12, 8'h10, 8'h7F, 8'h17};
        logic [11:0] exps  [5] = '{12'hA64, 12'h024, 12'hFFC, 12'h000, 12'hFFC};
        spi_read = 1'b1;
        for (int a = 0; a < 5; a++) begin
            spi_address = addrs[a];
            tick();
            n_tests++;
            if (spi_data_out !== exps[a]) begin
                n_fail++;
                $display("FAIL spi_read_%h: got %h expected %h", addrs[a], spi_data_out, exps[a]);
            end
        end
        spi_address = 8'h00;
        tick();
        spi_read = 1'b0;
        spi_address = 8'h12;
        tick();
        tick();
        n_tests++;
        if (spi_data_out !== 12'hA64) begin
            n_fail++;
            $display("FAIL spi_hold: got %h expected a64", spi_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_saturation();
        test_overflow();
        test_spi();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
